axi_wdata_drain: RTL and testbench

- Reader-side partner of the write-data buffer FIFO. Pops beats from the FIFO's first-word-fall-through head and drives them onto an AXI4 write-data (W) channel.
- Sends one burst per accepted command and generates WLAST.
- Sits between the write-data FIFO and the AXI interconnect, inside the master's write path.

---
 rtl/axi_wdata_drain.sv | 146 ++++++++++++++
 tb/tb_axi_wdata_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wdata_drain.sv
// Drains a first-word-fall-through write-data FIFO onto an AXI4 W channel, one burst per command, with WLAST.
// Define AXI_WDATA_DRAIN_TIMEOUT_EN to build the sticky W-channel stall timeout flag; otherwise timeout_err is tied low.
module axi_wdata_drain #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      cmd_valid,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    output logic                      cmd_ready,
    input  logic                      fifo_empty,
    input  logic [DATA_WIDTH-1:0]     fifo_head,
    output logic                      fifo_read_en,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      busy,
    output logic                      timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // One extra bit so an all-ones cmd_len counts 2^LEN_WIDTH beats without wrapping.
    localparam int CNT_W = LEN_WIDTH + 1;

    if ((TIMEOUT_CYCLES < 2) || ((DATA_WIDTH % 8) != 0)) begin : g_param_check
        $error("axi_wdata_drain: TIMEOUT_CYCLES must be >= 2 and DATA_WIDTH a multiple of 8");
    end

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        load_cnt_r;
    logic                    wvalid_r;
    logic                    wlast_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    load_s;
    logic                    beat_done_s;
    logic                    cmd_take_s;

    assign cmd_take_s  = (state_r == ST_IDLE) && cmd_valid;
    assign beat_done_s = wvalid_r && wready;
    assign load_s      = (state_r == ST_SEND) && (load_cnt_r != {CNT_W{1'b0}}) &&
                         !fifo_empty && (!wvalid_r || wready);

    assign cmd_ready    = (state_r == ST_IDLE);
    assign busy         = (state_r == ST_SEND);
    assign fifo_read_en = load_s;
    assign wvalid       = wvalid_r;
    assign wdata        = wdata_r;
    assign wlast        = wlast_r;
    assign wstrb        = {(DATA_WIDTH/8){1'b1}};

    // Next-state logic: a burst ends on the handshake of the beat carrying WLAST.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_done_s && wlast_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Beat counter and W output register; a loaded beat is held until its handshake.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            load_cnt_r <= {CNT_W{1'b0}};
            wvalid_r   <= 1'b0;
            wlast_r    <= 1'b0;
            wdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (cmd_take_s) begin
                load_cnt_r <= {1'b0, cmd_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
            end else if (load_s) begin
                load_cnt_r <= load_cnt_r - {{LEN_WIDTH{1'b0}}, 1'b1};
            end
            if (load_s) begin
                wdata_r  <= fifo_head;
                wvalid_r <= 1'b1;
                wlast_r  <= (load_cnt_r == {{LEN_WIDTH{1'b0}}, 1'b1});
            end else if (beat_done_s) begin
                wvalid_r <= 1'b0;
                wlast_r  <= 1'b0;
            end
        end
    end

`ifdef AXI_WDATA_DRAIN_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt_r;
    logic               timeout_err_r;
    logic               stall_s;

    assign stall_s     = wvalid_r && !wready;
    assign timeout_err = timeout_err_r;

    // Consecutive-stall counter; the flag fires on the TIMEOUT_CYCLES-th stall cycle and stays set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_r   <= {STALL_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (!stall_s) begin
                stall_cnt_r <= {STALL_W{1'b0}};
            end else if (stall_cnt_r != STALL_MAX) begin
                stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
            end
            if (stall_s && (stall_cnt_r == STALL_MAX)) begin
                timeout_err_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wdata_drain.sv
// Randomized and directed bench for axi_wdata_drain, checked against a queue-based model of the FIFO and W stream.
module tb_axi_wdata_drain;

    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          clr;
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          cmd_ready;
    logic          fifo_empty;
    logic [DW-1:0] fifo_head;
    logic          fifo_read_en;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wlast;
    logic          busy;
    logic          timeout_err;

    axi_wdata_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .fifo_empty(fifo_empty), .fifo_head(fifo_head), .fifo_read_en(fifo_read_en),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: FIFO contents, popped-but-unsent words, burst progress, stall history.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_busy = 0;
    int            m_beats = 0, m_sent = 0, m_pops = 0;
    int            stall_run = 0;
    bit            m_terr = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    // Values sampled on the falling edge of the last step.
    logic          s_rd, s_wv, s_wl, s_cr, s_te, s_hs, s_stall, s_acc;
    logic [DW-1:0] s_wd;
    logic [LW-1:0] s_len;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_head  = fifo_empty ? {DW{1'b0}} : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        sync_fifo();
    endtask

    task automatic model_reset();
        m_busy = 0; m_beats = 0; m_sent = 0; m_pops = 0;
        exp_q.delete();
        stall_run = 0; m_terr = 0; prev_stall = 0;
    endtask

    // One clock: check outputs on the falling edge, then advance the model just after the rising edge.
    task automatic step();
        @(negedge clk);
        s_rd = fifo_read_en; s_wv = wvalid; s_wd = wdata; s_wl = wlast;
        s_cr = cmd_ready; s_te = timeout_err; s_len = cmd_len;
        s_hs = wvalid && wready; s_stall = wvalid && !wready; s_acc = cmd_valid && cmd_ready;
        check_eq("rd_when_empty", 64'(s_rd & fifo_empty), 64'd0);
        check_eq("cmd_ready", 64'(s_cr), 64'(!m_busy));
        check_eq("busy", 64'(busy), 64'(m_busy));
        check_eq("timeout_err", 64'(s_te), 64'(m_terr));
        if (prev_stall) begin
            check_eq("hold_wvalid", 64'(s_wv), 64'd1);
            check_eq("hold_wdata", 64'(s_wd), 64'(prev_d));
            check_eq("hold_wlast", 64'(s_wl), 64'(prev_l));
        end
        if (s_rd) check_eq("pop_overrun", 64'(m_pops < m_beats), 64'd1);
        if (s_hs) begin
            check_eq("beat_has_pop", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_eq("wdata", 64'(s_wd), 64'(exp_q[0]));
            check_eq("wlast", 64'(s_wl), 64'((m_sent + 1) == m_beats));
            check_eq("wstrb", 64'(wstrb), 64'hF);
        end
        @(posedge clk);
        #1;
        if (s_rd && fifo_q.size() != 0) begin
            exp_q.push_back(fifo_q.pop_front());
            m_pops++;
        end
        if (s_hs) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            m_sent++;
            if (m_sent == m_beats) m_busy = 0;
        end
        if (s_acc && !clr) begin
            m_busy = 1; m_beats = int'(s_len) + 1; m_sent = 0; m_pops = 0;
        end
        stall_run = s_stall ? stall_run + 1 : 0;
`ifdef AXI_WDATA_DRAIN_TIMEOUT_EN
        if (stall_run >= TO) m_terr = 1;
`endif
        prev_stall = s_stall; prev_d = s_wd; prev_l = s_wl;
        sync_fifo();
    endtask

    task automatic do_reset();
        clr = 1'b1; cmd_valid = 1'b0;
        #2;
        check_eq("rst_wvalid", 64'(wvalid), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rd", 64'(fifo_read_en), 64'd0);
        check_eq("rst_wlast", 64'(wlast), 64'd0);
        check_eq("rst_wdata", 64'(wdata), 64'd0);
        check_eq("rst_timeout", 64'(timeout_err), 64'd0);
        model_reset();
        step();
        clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_reached", 64'(m_busy), 64'd0);
    endtask

    logic [6:0] rd_h, wv_h, cr_h;
    logic [DW-1:0] t2_d;
    logic          t2_l;
    bit            t2_seen;

    initial begin
        clr = 1'b1; cmd_valid = 1'b0; cmd_len = '0; wready = 1'b1;
        sync_fifo();
        #1;
        do_reset();

        // 1: four-beat burst with exact latency.
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        cmd_len = 8'd3; cmd_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            rd_h[c] = s_rd; wv_h[c] = s_wv; cr_h[c] = s_cr;
            cmd_valid = 1'b0;
        end
        for (int c = 0; c < 7; c++) begin
            check_eq("t1_rd_cycle", 64'(rd_h[c]), 64'(c >= 1 && c <= 4));
            check_eq("t1_wvalid_cycle", 64'(wv_h[c]), 64'(c >= 2 && c <= 5));
        end
        check_eq("t1_cmd_ready_c5", 64'(cr_h[5]), 64'd0);
        check_eq("t1_cmd_ready_c6", 64'(cr_h[6]), 64'd1);

        // 2: single beat.
        push(32'hDEADBEEF);
        cmd_len = 8'd0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        t2_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_hs && !t2_seen) begin t2_d = s_wd; t2_l = s_wl; t2_seen = 1; end
        end
        check_eq("t2_seen", 64'(t2_seen), 64'd1);
        check_eq("t2_wdata", 64'(t2_d), 64'hDEADBEEF);
        check_eq("t2_wlast", 64'(t2_l), 64'd1);
        check_eq("t2_idle", 64'(cmd_ready), 64'd1);

        // 3: stall on beat 1.
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        cmd_len = 8'd3; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        wready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("t3_stall_rd", 64'(s_rd), 64'd0);
            check_eq("t3_stall_wv", 64'(s_wv), 64'd1);
        end
        wready = 1'b1;
        wait_idle(50);

        // 4: FIFO runs dry mid-burst.
        push(32'hC0); push(32'hC1);
        cmd_len = 8'd3; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check_eq("t4_dry_wvalid", 64'(s_wv), 64'd0);
        push(32'hC2); push(32'hC3);
        wait_idle(50);

        // 5: reset during beat 2, then a two-beat burst from what remains.
        for (int i = 0; i < 8; i++) push(32'hD0 + 32'(i));
        cmd_len = 8'd7; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && !(s_wv && m_sent == 1); c++) step();
        check_eq("t5_on_beat2", 64'(m_sent), 64'd1);
        do_reset();
        cmd_len = 8'd1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        wait_idle(50);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_len   = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(8, 40)) : LW'($urandom_range(0, 7));
            wready    = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) push($urandom);
            step();
        end
        cmd_valid = 1'b0; wready = 1'b1;
        for (int c = 0; c < 200 && m_busy; c++) begin
            if (fifo_q.size() < 4) push($urandom);
            step();
        end
        check_eq("rand_drained", 64'(m_busy), 64'd0);

        // 6: W-channel stall timeout.
        do_reset();
        push(32'hE0);
        cmd_len = 8'd0; cmd_valid = 1'b1; wready = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c < 10 && !s_wv; c++) step();
        for (int k = 2; k <= TO; k++) step();
        check_eq("t6_before", 64'(s_te), 64'd0);
        step();
`ifdef AXI_WDATA_DRAIN_TIMEOUT_EN
        check_eq("t6_set", 64'(s_te), 64'd1);
`else
        check_eq("t6_set", 64'(s_te), 64'd0);
`endif
        wready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check_eq("t6_sticky", 64'(s_te), 64'(m_terr));
        check_eq("t6_idle", 64'(m_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
